sram_cmd_serializer: RTL and testbench

- Host-side command front-end sitting directly upstream of the SRAM top.
- Accepts parallel read/write commands over a valid/ready handshake.
- Serialises write data MSB-first onto serial_in/shift, then issues w_en or r_en with the address.
- Collects read data on data_valid and returns it over a response handshake, with read timeout detection.

---
 rtl/sram_cmd_serializer.sv | 207 ++++++++++++++++++++
 tb/tb_sram_cmd_serializer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_cmd_serializer.sv
// sram_cmd_serializer: host-side command front-end for the serial-load SRAM.
// Takes one read or write command at a time over a valid/ready handshake.
// Writes are shifted out MSB-first on serial_in/shift and then committed with
// w_en. Reads pulse r_en, wait (bounded) for data_valid and return the word
// over a response handshake.
//
// Optional feature (compile-time macro SRAM_SER_WR_VERIFY_EN): every write is
// read back from the same row and answered with the read word; rsp_err flags a
// mismatch or a timeout.
//
// Ports:
//   clk, arst_n            clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready    command handshake; cmd_we, cmd_addr, cmd_wdata payload
//   rsp_valid/rsp_ready    response handshake; rsp_rdata, rsp_err payload
//   serial_in, shift       serial write data and strobe to the SRAM
//   w_en, r_en, addr       write/read strobes and row address to the SRAM
//   data_valid, data_out   read data returned by the SRAM
//   busy                   high whenever a command is in flight
module sram_cmd_serializer #(
    parameter int unsigned ROWS       = 16,
    parameter int unsigned COLS       = 8,
    parameter int unsigned BIT_CYCLES = 2,
    parameter int unsigned RD_TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_we,
    input  logic [$clog2(ROWS)-1:0]  cmd_addr,
    input  logic [COLS-1:0]          cmd_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [COLS-1:0]          rsp_rdata,
    output logic                     rsp_err,
    output logic                     serial_in,
    output logic                     shift,
    output logic                     w_en,
    output logic                     r_en,
    output logic [$clog2(ROWS)-1:0]  addr,
    input  logic                     data_valid,
    input  logic [COLS-1:0]          data_out,
    output logic                     busy
);

    localparam int unsigned AW = $clog2(ROWS);
    localparam int unsigned BW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned HW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int unsigned TW = $clog2(RD_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_WRITE,
        S_READ,
        S_WAIT_RD,
        S_RESP
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [TW-1:0]   to_q, to_d;
    // Write word, rotated left once per bit; after COLS bits it is back to the
    // original value, which the read-back compare relies on.
    logic [COLS-1:0] data_q, data_d;
    logic [AW-1:0]   addr_d;
    logic [COLS-1:0] rdata_d;
    logic            err_d;
    logic            cmd_ready_d, busy_d, shift_d, serial_in_d;
    logic            w_en_d, r_en_d, rsp_valid_d;
`ifdef SRAM_SER_WR_VERIFY_EN
    logic            we_q, we_d;
`endif

    // State, counters and all registered outputs
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= S_IDLE;
            bit_q     <= '0;
            hold_q    <= '0;
            to_q      <= '0;
            data_q    <= '0;
            addr      <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            shift     <= 1'b0;
            serial_in <= 1'b0;
            w_en      <= 1'b0;
            r_en      <= 1'b0;
            rsp_valid <= 1'b0;
`ifdef SRAM_SER_WR_VERIFY_EN
            we_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bit_q     <= bit_d;
            hold_q    <= hold_d;
            to_q      <= to_d;
            data_q    <= data_d;
            addr      <= addr_d;
            rsp_rdata <= rdata_d;
            rsp_err   <= err_d;
            cmd_ready <= cmd_ready_d;
            busy      <= busy_d;
            shift     <= shift_d;
            serial_in <= serial_in_d;
            w_en      <= w_en_d;
            r_en      <= r_en_d;
            rsp_valid <= rsp_valid_d;
`ifdef SRAM_SER_WR_VERIFY_EN
            we_q      <= we_d;
`endif
        end
    end

    // Next-state logic; outputs are decoded from the next state so they line
    // up with the state they belong to.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        hold_d  = hold_q;
        to_d    = to_q;
        data_d  = data_q;
        addr_d  = addr;
        rdata_d = rsp_rdata;
        err_d   = rsp_err;
`ifdef SRAM_SER_WR_VERIFY_EN
        we_d    = we_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    addr_d  = cmd_addr;
                    data_d  = cmd_wdata;
                    bit_d   = '0;
                    hold_d  = '0;
`ifdef SRAM_SER_WR_VERIFY_EN
                    we_d    = cmd_we;
`endif
                    state_d = cmd_we ? S_SHIFT : S_READ;
                end
            end
            S_SHIFT: begin
                if (hold_q == HW'(BIT_CYCLES - 1)) begin
                    hold_d = '0;
                    data_d = {data_q[COLS-2:0], data_q[COLS-1]};
                    if (bit_q == BW'(COLS - 1)) begin
                        state_d = S_WRITE;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            S_WRITE: begin
`ifdef SRAM_SER_WR_VERIFY_EN
                state_d = S_READ;
`else
                state_d = S_IDLE;
`endif
            end
            S_READ: begin
                to_d    = '0;
                state_d = S_WAIT_RD;
            end
            S_WAIT_RD: begin
                // Data has priority over a timeout landing in the same cycle
                if (data_valid) begin
                    rdata_d = data_out;
`ifdef SRAM_SER_WR_VERIFY_EN
                    err_d   = we_q && (data_out != data_q);
`else
                    err_d   = 1'b0;
`endif
                    state_d = S_RESP;
                end else begin
                    to_d = to_q + TW'(1);
                    if (to_d == TW'(RD_TIMEOUT)) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (rsp_valid && rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        shift_d     = (state_d == S_SHIFT);
        serial_in_d = shift_d && data_d[COLS-1];
        w_en_d      = (state_d == S_WRITE);
        r_en_d      = (state_d == S_READ);
        rsp_valid_d = (state_d == S_RESP);
    end

endmodule

// File: tb/tb_sram_cmd_serializer.sv
// Directed bench for sram_cmd_serializer with a small behavioural SRAM model.
module tb_sram_cmd_serializer;

    localparam int unsigned ROWS       = 16;
    localparam int unsigned COLS       = 8;
    localparam int unsigned BIT_CYCLES = 2;
    localparam int unsigned RD_TIMEOUT = 16;
    localparam int unsigned AW         = 4;

    logic            clk = 1'b0;
    logic            arst_n;
    logic            cmd_valid, cmd_ready, cmd_we;
    logic [AW-1:0]   cmd_addr;
    logic [COLS-1:0] cmd_wdata;
    logic            rsp_valid, rsp_ready, rsp_err;
    logic [COLS-1:0] rsp_rdata;
    logic            serial_in, shift, w_en, r_en, busy;
    logic [AW-1:0]   addr;
    logic            data_valid = 1'b0;
    logic [COLS-1:0] data_out = '0;

    int checks   = 0;
    int failures = 0;

    logic [COLS-1:0] mem     [ROWS];
    logic [COLS-1:0] corrupt [ROWS];
    int              rd_lat;
    int              pend;
    int              sh_cnt;
    logic [COLS-1:0] sr;
    logic [AW-1:0]   raddr;

    always #5 clk = ~clk;

    sram_cmd_serializer #(
        .ROWS(ROWS), .COLS(COLS), .BIT_CYCLES(BIT_CYCLES), .RD_TIMEOUT(RD_TIMEOUT)
    ) dut (
        .clk(clk), .arst_n(arst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .serial_in(serial_in), .shift(shift), .w_en(w_en), .r_en(r_en),
        .addr(addr), .data_valid(data_valid), .data_out(data_out), .busy(busy)
    );

    // SRAM model: samples on the falling edge, returns read data rd_lat cycles
    // after r_en (rd_lat=0 means it never answers).
    initial begin
        pend   = 0;
        sh_cnt = 0;
        sr     = '0;
        raddr  = '0;
        forever begin
            @(negedge clk);
            data_valid = 1'b0;
            if (!arst_n) begin
                pend   = 0;
                sh_cnt = 0;
            end else begin
                if (shift) begin
                    sh_cnt++;
                    if (sh_cnt == BIT_CYCLES) begin
                        sr     = {sr[COLS-2:0], serial_in};
                        sh_cnt = 0;
                    end
                end
                if (w_en) mem[addr] = sr;
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        data_valid = 1'b1;
                        data_out   = mem[raddr] ^ corrupt[raddr];
                    end
                end
                if (r_en && rd_lat > 0) begin
                    pend  = rd_lat;
                    raddr = addr;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a command and return in the first cycle after it is accepted
    task automatic send(input logic we, input logic [AW-1:0] a, input logic [COLS-1:0] d);
        int n;
        n         = 0;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = a;
        cmd_wdata = d;
        while (!cmd_ready && n < 200) begin
            tick();
            n++;
        end
        check("cmd_ready_wait", 32'(cmd_ready), 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    // Wait for a response, check it, hold it under backpressure, then consume
    task automatic get_rsp(input string tag, input int exp_lat, input logic [COLS-1:0] exp_data,
                           input logic exp_err, input int hold);
        int lat;
        lat = 0;
        while (!rsp_valid && lat < 100) begin
            tick();
            lat++;
        end
        check({tag, "_valid"}, 32'(rsp_valid), 1);
        if (exp_lat >= 0) check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_rdata"}, 32'(rsp_rdata), 32'(exp_data));
        check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1;
            cmd_we    = 1'b0;
            cmd_addr  = '0;
            tick();
            check({tag, "_hold_valid"}, 32'(rsp_valid), 1);
            check({tag, "_hold_rdata"}, 32'(rsp_rdata), 32'(exp_data));
            check({tag, "_hold_err"}, 32'(rsp_err), 32'(exp_err));
            check({tag, "_hold_ready"}, 32'(cmd_ready), 0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({tag, "_done_valid"}, 32'(rsp_valid), 0);
        check({tag, "_done_ready"}, 32'(cmd_ready), 1);
        check({tag, "_done_busy"}, 32'(busy), 0);
    endtask

    logic [COLS-1:0] pat;
    logic [COLS-1:0] v;

    initial begin
        arst_n    = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        rd_lat    = 2;
        for (int i = 0; i < ROWS; i++) begin
            mem[i]     = '0;
            corrupt[i] = '0;
        end

        // Reset state
        #12;
        check("rst_cmd_ready", 32'(cmd_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_shift", 32'(shift), 0);
        check("rst_serial", 32'(serial_in), 0);
        check("rst_w_en", 32'(w_en), 0);
        check("rst_r_en", 32'(r_en), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_err", 32'(rsp_err), 0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 0);
        check("rst_addr", 32'(addr), 0);
        tick();
        tick();
        arst_n = 1'b1;
        check("rel_ready_pre", 32'(cmd_ready), 0);
        tick();
        check("rel_ready_post", 32'(cmd_ready), 1);

        // Write 8'hA5 to row 5: bits 1,0,1,0,0,1,0,1 each held BIT_CYCLES
        pat = 8'hA5;
        send(1'b1, 4'd5, pat);
        for (int k = 0; k < COLS; k++) begin
            for (int j = 0; j < BIT_CYCLES; j++) begin
                check("wr_shift", 32'(shift), 1);
                check("wr_serial", 32'(serial_in), 32'(pat[COLS-1-k]));
                check("wr_busy_ready", 32'(cmd_ready), 0);
                tick();
            end
        end
        check("wr_w_en", 32'(w_en), 1);
        check("wr_addr", 32'(addr), 5);
        check("wr_shift_off", 32'(shift), 0);
        check("wr_serial_off", 32'(serial_in), 0);
        check("wr_ready_low", 32'(cmd_ready), 0);
        tick();
        check("wr_w_en_once", 32'(w_en), 0);
`ifdef SRAM_SER_WR_VERIFY_EN
        get_rsp("wr_a5", -1, 8'hA5, 1'b0, 0);
`else
        check("wr_idle_ready", 32'(cmd_ready), 1);
        check("wr_idle_busy", 32'(busy), 0);
`endif
        check("wr_mem5", 32'(mem[5]), 32'h A5);

        // Reset during bit 3 of a write aborts it
        send(1'b1, 4'd7, 8'hFF);
        repeat (6) tick();
        check("mid_shift_on", 32'(shift), 1);
        arst_n = 1'b0;
        #1;
        check("mid_rst_shift", 32'(shift), 0);
        check("mid_rst_serial", 32'(serial_in), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_ready", 32'(cmd_ready), 0);
        check("mid_rst_addr", 32'(addr), 0);
        repeat (3) begin
            tick();
            check("mid_rst_no_w_en", 32'(w_en), 0);
        end
        arst_n = 1'b1;
        check("mid_rel_ready_pre", 32'(cmd_ready), 0);
        tick();
        check("mid_rel_ready_post", 32'(cmd_ready), 1);
        tick();
        check("mid_rel_no_w_en", 32'(w_en), 0);
        check("mid_mem7", 32'(mem[7]), 0);

        // Read row 3 (data two cycles after r_en) with 5 cycles of backpressure
        mem[3] = 8'h3C;
        rd_lat = 2;
        send(1'b0, 4'd3, '0);
        check("rd_r_en", 32'(r_en), 1);
        check("rd_addr", 32'(addr), 3);
        check("rd_ready_low", 32'(cmd_ready), 0);
        tick();
        check("rd_r_en_once", 32'(r_en), 0);
        get_rsp("rd3", 2, 8'h3C, 1'b0, 5);
        check("rd_addr_kept", 32'(addr), 3);

        // No data: timeout after RD_TIMEOUT wait cycles
        rd_lat = 0;
        send(1'b0, 4'd9, '0);
        get_rsp("rd_to", 17, 8'h00, 1'b1, 0);

        // Data arriving in the timeout cycle wins
        mem[9] = 8'h5A;
        rd_lat = 16;
        send(1'b0, 4'd9, '0);
        get_rsp("rd_edge", 17, 8'h5A, 1'b0, 0);

        // Data one cycle late: timeout, and the stray data_valid in RESP is ignored
        rd_lat = 17;
        send(1'b0, 4'd9, '0);
        get_rsp("rd_late", 17, 8'h00, 1'b1, 2);

        // Back-to-back: write every row with row^FF, then read them all back
        rd_lat = 1;
        for (int r = 0; r < ROWS; r++) begin
            v = COLS'(r) ^ 8'hFF;
            send(1'b1, AW'(r), v);
`ifdef SRAM_SER_WR_VERIFY_EN
            get_rsp("b2b_wr", -1, v, 1'b0, 0);
`endif
        end
        for (int r = 0; r < ROWS; r++) begin
            v = COLS'(r) ^ 8'hFF;
            send(1'b0, AW'(r), '0);
            get_rsp("b2b_rd", 2, v, 1'b0, 0);
        end

`ifdef SRAM_SER_WR_VERIFY_EN
        // Read-back of a corrupted row flags an error
        corrupt[6] = 8'h10;
        send(1'b1, 4'd6, 8'h66);
        get_rsp("wr_bad", -1, 8'h76, 1'b1, 0);
        corrupt[6] = '0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
